// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU (IDLE/EXEC/RESP).
// Define ALU_MULDIV_STALL_EN to stretch MUL/DIV EXEC to MULDIV_CYCLES cycles.
module alu_arbiter #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_oprd1,
    input  logic [31:0] req0_oprd2,
    input  logic [31:0] req1_oprd1,
    input  logic [31:0] req1_oprd2,
    input  logic [3:0]  req0_option,
    input  logic [3:0]  req1_option,
    output logic [31:0] alu_oprd1,
    output logic [31:0] alu_oprd2,
    output logic [3:0]  alu_option,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_divz
);

`ifdef ALU_MULDIV_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif
    localparam logic [3:0] MULDIV_LAST = 4'(MULDIV_CYCLES - 1);
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic [3:0] exec_max;
    logic       exec_last;
    logic       last_grant;
    logic       owner;
    logic       win;
    logic       can_grant;
    logic       accept;
    logic       divz;

    // Ready is gated by rst_n so no grant is visible while reset is held.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid)
            win = ~last_grant;
        else if (req1_valid)
            win = 1'b1;
        can_grant  = rst_n && (state == IDLE || state == RESP);
        req0_ready = can_grant && req0_valid && !win;
        req1_ready = can_grant && req1_valid && win;
        accept     = req0_ready || req1_ready;
        rsp_valid  = (state == RESP);
        exec_max   = (STALL_EN && (alu_option == OP_MUL || alu_option == OP_DIV))
                     ? MULDIV_LAST : 4'd0;
        exec_last  = (cnt == exec_max);
        divz       = (alu_option == OP_DIV) && (alu_oprd2 == '0);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = EXEC;
            EXEC: if (exec_last) state_nx = RESP;
            RESP: state_nx = accept ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_oprd1  <= '0;
            alu_oprd2  <= '0;
            alu_option <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_divz   <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= '0;
                owner      <= win;
                last_grant <= win;
                alu_oprd1  <= win ? req1_oprd1  : req0_oprd1;
                alu_oprd2  <= win ? req1_oprd2  : req0_oprd2;
                alu_option <= win ? req1_option : req0_option;
            end else if (state == EXEC) begin
                if (!exec_last) begin
                    cnt <= cnt + 4'd1;
                end else begin
                    rsp_id     <= owner;
                    rsp_divz   <= divz;
                    rsp_result <= divz ? '1 : alu_result;
                    rsp_zero   <= divz ? 1'b0 : alu_zero;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus reset and contention sequences.
module tb_alu_arbiter;
    localparam int unsigned MD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_oprd1, req0_oprd2, req1_oprd1, req1_oprd2;
    logic [3:0]  req0_option, req1_option;
    logic [31:0] alu_oprd1, alu_oprd2, alu_result;
    logic [3:0]  alu_option;
    logic        alu_zero;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_divz;
    logic [31:0] rsp_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.MULDIV_CYCLES(MD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_oprd1(req0_oprd1), .req0_oprd2(req0_oprd2),
        .req1_oprd1(req1_oprd1), .req1_oprd2(req1_oprd2),
        .req0_option(req0_option), .req1_option(req1_option),
        .alu_oprd1(alu_oprd1), .alu_oprd2(alu_oprd2), .alu_option(alu_option),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_divz(rsp_divz)
    );

    // Shared ALU stand-in; unknown codes fall through to XOR, DIV by zero yields a marker.
    always_comb begin
        case (alu_option)
            4'b0000: alu_result = alu_oprd1 + alu_oprd2;
            4'b0001: alu_result = alu_oprd1 - alu_oprd2;
            4'b0010: alu_result = alu_oprd1 & alu_oprd2;
            4'b0011: alu_result = alu_oprd1 | alu_oprd2;
            4'b1000: alu_result = alu_oprd1 * alu_oprd2;
            4'b1001: alu_result = (alu_oprd2 == '0) ? 32'h0000_1234 : alu_oprd1 / alu_oprd2;
            default: alu_result = alu_oprd1 ^ alu_oprd2;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic        id;
        logic [3:0]  opt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        divz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int exp_lat;
        exp_lat = 2;
`ifdef ALU_MULDIV_STALL_EN
        if (v.opt == 4'b1000 || v.opt == 4'b1001) exp_lat = MD + 1;
`endif
        req0_valid = !v.id; req1_valid = v.id;
        req0_oprd1 = v.a; req0_oprd2 = v.b; req0_option = v.opt;
        req1_oprd1 = v.a; req1_oprd2 = v.b; req1_option = v.opt;
        @(negedge clk);
        chk("ready_win", {31'd0, v.id ? req1_ready : req0_ready}, 32'd1);
        chk("ready_lose", {31'd0, v.id ? req0_ready : req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (alu_oprd1 !== v.a || alu_oprd2 !== v.b || alu_option !== v.opt)
                chk("alu_stable", {alu_option, 28'd0} ^ alu_oprd1, {v.opt, 28'd0} ^ v.a);
            if (rsp_valid) break;
            lat++;
            tick();
        end
        chk("latency", lat, exp_lat);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, v.id});
        chk("rsp_result", rsp_result, v.res);
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, v.zero});
        chk("rsp_divz", {31'd0, rsp_divz}, {31'd0, v.divz});
        tick();
        @(negedge clk);
        chk("rsp_pulse_one", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_hold", rsp_result, v.res);
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {30'd0, req0_ready, req1_ready}, 32'd0);
        chk({tag, "_rsp"}, {28'd0, rsp_valid, rsp_id, rsp_zero, rsp_divz}, 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_alu"}, alu_oprd1 | alu_oprd2 | {28'd0, alu_option}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int grants, rsps, last_c, exp_gid, exp_rid, quiet;

        vecs[0] = '{1'b0, 4'b0000, 32'd5,    32'd7,      32'd12,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'b0001, 32'd9,    32'd9,      32'd0,          1'b1, 1'b0};
        vecs[2] = '{1'b0, 4'b0011, 32'd1,    32'd2,      32'd3,          1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'b1001, 32'd100,  32'd0,      32'hFFFF_FFFF,  1'b0, 1'b1};
        vecs[4] = '{1'b0, 4'b1001, 32'd100,  32'd7,      32'd14,         1'b0, 1'b0};
        vecs[5] = '{1'b1, 4'b1000, 32'd6,    32'd7,      32'd42,         1'b0, 1'b0};
        vecs[6] = '{1'b0, 4'b1011, 32'd5,    32'd3,      32'd6,          1'b0, 1'b0};
        vecs[7] = '{1'b1, 4'b0010, 32'hF0F0, 32'h0FF0,   32'h00F0,       1'b0, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_oprd1 = 32'd5; req0_oprd2 = 32'd7; req0_option = 4'b0000;
        req1_oprd1 = '0; req1_oprd2 = '0; req1_option = '0;
        #12;
        chk_all_zero("reset");
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_edge_ready", {31'd0, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset pulsed while an ADD is in EXEC must discard it.
        req0_valid = 1'b1; req0_oprd1 = 32'd1; req0_oprd2 = 32'd1; req0_option = 4'b0000;
        tick();
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_exec");
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) quiet = 0;
        end
        chk("rst_discard", quiet, 1);
        tick();

        // Both requesters continuously valid: alternate grants, back-to-back every 2 cycles.
        req0_valid = 1'b1; req0_oprd1 = 32'd9; req0_oprd2 = 32'd9; req0_option = 4'b0001;
        req1_valid = 1'b1; req1_oprd1 = 32'd1; req1_oprd2 = 32'd2; req1_option = 4'b0011;
        grants = 0; rsps = 0; last_c = 0; exp_gid = 0; exp_rid = 0;
        for (int c = 0; c < 30 && rsps < 4; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) chk("one_ready", 32'd2, 32'd1);
            if (req0_ready || req1_ready) begin
                chk("rr_grant", {31'd0, req1_ready}, exp_gid);
                exp_gid ^= 1;
                grants++;
            end
            if (rsp_valid) begin
                chk("rr_rsp_id", {31'd0, rsp_id}, exp_rid);
                chk("rr_result", rsp_result, exp_rid ? 32'd3 : 32'd0);
                chk("rr_zero", {31'd0, rsp_zero}, exp_rid ? 32'd0 : 32'd1);
                if (rsps > 0) chk("b2b_gap", c - last_c, 2);
                last_c = c;
                exp_rid ^= 1;
                rsps++;
            end
            tick();
            if (grants >= 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        chk("rr_rsp_count", rsps, 4);
        chk("rr_grant_count", grants, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
